frame_scheduler: RTL and testbench

- Sequences the DSP core once per audio frame.
- Buffers the latest ADAT input frame and issues a one-cycle start to the DSP core on each output frame tick.
- Waits for DSP completion, then saturates and registers the DSP results onto the output audio bus.
- Sits between adat_in / adat_out and DSPCore, in the DSP clock domain; owns all frame-level flow accounting (overrun, underrun, late tick, DSP timeout) and sticky per-channel clip flags.

---
 rtl/mixer_pkg.sv | 19 +
 rtl/sat_counter.sv | 33 +++
 rtl/saturate.sv | 38 +++
 rtl/frame_scheduler.sv | 170 +++++++++++++++++
 tb/tb_frame_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - shared sample types, default widths and scheduler states for the mixer datapath
package mixer_pkg;

    localparam int DEF_CHANNELS  = 8;
    localparam int DEF_IN_WIDTH  = 24;
    localparam int DEF_DSP_WIDTH = 36;
    localparam int DEF_HEADROOM  = 6;
    localparam int DEF_FRAC_BITS = DEF_DSP_WIDTH - DEF_IN_WIDTH - DEF_HEADROOM;

    typedef logic signed [DEF_IN_WIDTH-1:0]  sample_t;
    typedef logic signed [DEF_DSP_WIDTH-1:0] dsp_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN
    } sched_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
// clk, rst : clock and synchronous active-high reset
// inc      : count one event this cycle
// cnt      : current count
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/saturate.sv
// rtl/saturate.sv - clamp a headroom-extended DSP sample back to the output sample width
// din  : IN_WIDTH signed value with HEADROOM integer guard bits
// dout : OUT_WIDTH saturated sample
// clip : high when din did not fit and dout was clamped
module saturate #(
    parameter int IN_WIDTH  = 36,
    parameter int HEADROOM  = 6,
    parameter int OUT_WIDTH = 24
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 clip
);

    // Kept window sits directly below the guard bits; anything below it is fraction.
    localparam int TOP = IN_WIDTH - HEADROOM - 1;
    localparam int LSB = TOP - OUT_WIDTH + 1;

    logic              sign_bit;
    logic [HEADROOM:0] guard_bits;
    logic              unused_lsbs;

    always_comb begin
        sign_bit   = din[IN_WIDTH-1];
        guard_bits = din[IN_WIDTH-1:TOP];
        clip       = (guard_bits != {(HEADROOM + 1){sign_bit}});
        if (!clip) begin
            dout = din[TOP:LSB];
        end else if (sign_bit) begin
            dout = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end
    end

    assign unused_lsbs = ^din[LSB-1:0];

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame DSP sequencer with input buffering, output saturation and flow accounting
// in_valid/in_bus       : new input frame, buffered in pend
// frame_tick            : output frame slot, kicks one DSP pass
// dsp_start/dsp_in      : start pulse and registered operands to the DSP core
// dsp_done/dsp_out      : DSP completion and results
// out_valid/out_bus     : saturated registered results
// clip/clip_clear       : sticky per-channel clip flags
// busy, *_cnt           : activity flag and saturating flow-error counters
module frame_scheduler #(
    parameter int CHANNELS  = mixer_pkg::DEF_CHANNELS,
    parameter int IN_WIDTH  = mixer_pkg::DEF_IN_WIDTH,
    parameter int DSP_WIDTH = mixer_pkg::DEF_DSP_WIDTH,
    parameter int HEADROOM  = mixer_pkg::DEF_HEADROOM,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [CHANNELS-1:0][IN_WIDTH-1:0]    in_bus,
    input  logic                                 frame_tick,
    output logic                                 dsp_start,
    output logic [CHANNELS-1:0][DSP_WIDTH-1:0]   dsp_in,
    input  logic                                 dsp_done,
    input  logic [CHANNELS-1:0][DSP_WIDTH-1:0]   dsp_out,
    output logic [CHANNELS-1:0][IN_WIDTH-1:0]    out_bus,
    output logic                                 out_valid,
    output logic [CHANNELS-1:0]                  clip,
    input  logic                                 clip_clear,
    output logic                                 busy,
    output logic [CNT_WIDTH-1:0]                 overrun_cnt,
    output logic [CNT_WIDTH-1:0]                 underrun_cnt,
    output logic [CNT_WIDTH-1:0]                 late_cnt,
    output logic [CNT_WIDTH-1:0]                 timeout_cnt
);

    import mixer_pkg::*;

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int FRAC    = DSP_WIDTH - IN_WIDTH - HEADROOM;

    sched_state_t                       state_q, state_d;
    logic [CHANNELS-1:0][IN_WIDTH-1:0]  pend_q, pend_d;
    logic                               pend_full_q, pend_full_d;
    logic [CHANNELS-1:0][DSP_WIDTH-1:0] dsp_in_q, dsp_in_d;
    logic [CHANNELS-1:0][IN_WIDTH-1:0]  out_bus_q, out_bus_d;
    logic                               out_valid_q, out_valid_d;
    logic [CHANNELS-1:0]                clip_q, clip_d;
    logic [TIMER_W-1:0]                 timer_q, timer_d;

    logic [CHANNELS-1:0][IN_WIDTH-1:0]  sat_out;
    logic [CHANNELS-1:0]                sat_clip;
    logic overrun_inc, underrun_inc, late_inc, timeout_inc;
    logic take_pend, bypass;

    function automatic logic [DSP_WIDTH-1:0] to_operand(input logic [IN_WIDTH-1:0] s);
        return {{HEADROOM{s[IN_WIDTH-1]}}, s, {FRAC{1'b0}}};
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_sat
        saturate #(
            .IN_WIDTH (DSP_WIDTH),
            .HEADROOM (HEADROOM),
            .OUT_WIDTH(IN_WIDTH)
        ) u_sat (
            .din (dsp_out[i]),
            .dout(sat_out[i]),
            .clip(sat_clip[i])
        );
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        dsp_in_d     = dsp_in_q;
        out_bus_d    = out_bus_q;
        out_valid_d  = 1'b0;
        clip_d       = clip_clear ? '0 : clip_q;
        timer_d      = timer_q;
        overrun_inc  = 1'b0;
        underrun_inc = 1'b0;
        late_inc     = 1'b0;
        timeout_inc  = 1'b0;

        take_pend = (state_q == IDLE) && frame_tick && pend_full_q;
        bypass    = (state_q == IDLE) && frame_tick && !pend_full_q && in_valid;

        // A frame arriving on the transfer cycle refills pend behind the one
        // leaving, so only a genuine overwrite counts as overrun.
        if (take_pend) begin
            pend_full_d = 1'b0;
        end
        if (in_valid && !bypass) begin
            pend_d      = in_bus;
            pend_full_d = 1'b1;
            overrun_inc = pend_full_q && !take_pend;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (take_pend) begin
                        for (int i = 0; i < CHANNELS; i++) dsp_in_d[i] = to_operand(pend_q[i]);
                    end else if (bypass) begin
                        for (int i = 0; i < CHANNELS; i++) dsp_in_d[i] = to_operand(in_bus[i]);
                    end else begin
                        underrun_inc = 1'b1;
                    end
                    state_d = START;
                end
            end
            START: begin
                late_inc = frame_tick;
                timer_d  = '0;
                state_d  = RUN;
            end
            RUN: begin
                late_inc = frame_tick;
                if (dsp_done) begin
                    out_bus_d   = sat_out;
                    out_valid_d = 1'b1;
                    clip_d      = clip_d | sat_clip;
                    state_d     = IDLE;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    timeout_inc = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            dsp_in_q    <= '0;
            out_bus_q   <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            dsp_in_q    <= dsp_in_d;
            out_bus_q   <= out_bus_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            timer_q     <= timer_d;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_overrun  (.clk(clk), .rst(rst), .inc(overrun_inc),  .cnt(overrun_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_underrun (.clk(clk), .rst(rst), .inc(underrun_inc), .cnt(underrun_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_late     (.clk(clk), .rst(rst), .inc(late_inc),     .cnt(late_cnt));
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_timeout  (.clk(clk), .rst(rst), .inc(timeout_inc),  .cnt(timeout_cnt));

    assign dsp_start = (state_q == START);
    assign busy      = (state_q != IDLE);
    assign dsp_in    = dsp_in_q;
    assign out_bus   = out_bus_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - randomized self-checking bench for frame_scheduler against a frame-level model
module tb_frame_scheduler;

    localparam int CH   = 8;
    localparam int IW   = 24;
    localparam int DW   = 36;
    localparam int HR   = 6;
    localparam int TO   = 64;
    localparam int CW   = 4;
    localparam int FRAC = DW - IW - HR;
    localparam int CMAX = (1 << CW) - 1;

    typedef logic [CH-1:0][IW-1:0] frame_t;
    typedef logic [CH-1:0][DW-1:0] dframe_t;

    logic clk = 1'b0;
    logic rst, in_valid, frame_tick, dsp_done, clip_clear;
    frame_t in_bus, out_bus;
    dframe_t dsp_in, dsp_out;
    logic dsp_start, out_valid, busy;
    logic [CH-1:0] clip;
    logic [CW-1:0] overrun_cnt, underrun_cnt, late_cnt, timeout_cnt;

    always #5 clk = ~clk;

    frame_scheduler #(
        .CHANNELS(CH), .IN_WIDTH(IW), .DSP_WIDTH(DW), .HEADROOM(HR),
        .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bus(in_bus),
        .frame_tick(frame_tick), .dsp_start(dsp_start), .dsp_in(dsp_in),
        .dsp_done(dsp_done), .dsp_out(dsp_out), .out_bus(out_bus),
        .out_valid(out_valid), .clip(clip), .clip_clear(clip_clear), .busy(busy),
        .overrun_cnt(overrun_cnt), .underrun_cnt(underrun_cnt),
        .late_cnt(late_cnt), .timeout_cnt(timeout_cnt)
    );

    int checks = 0;
    int failures = 0;

    // model: frames held as values, a queue for the pending slot, and the
    // number of cycles since dsp_start (-1 when nothing is in flight)
    dframe_t m_din;
    frame_t  m_out;
    logic [CH-1:0] m_clip;
    bit      m_ov;
    int      m_cnt[4];
    int      m_ss;
    frame_t  pend_q[$];

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] operand(input logic [IW-1:0] s);
        longint v;
        v = longint'($signed(s)) * (longint'(1) << FRAC);
        return v[DW-1:0];
    endfunction

    function automatic dframe_t operands(input frame_t f);
        dframe_t d;
        for (int i = 0; i < CH; i++) d[i] = operand(f[i]);
        return d;
    endfunction

    // {clip, value}: the result must be representable as an IW-bit sample
    // once the fraction is dropped
    function automatic logic [IW:0] sat_ref(input logic [DW-1:0] v);
        longint q;
        longint smax;
        smax = (longint'(1) << (IW - 1)) - 1;
        q = longint'($signed(v)) >>> FRAC;
        if (q > smax) return {1'b1, 1'b0, {(IW - 1){1'b1}}};
        if (q < -smax - 1) return {1'b1, 1'b1, {(IW - 1){1'b0}}};
        return {1'b0, q[IW-1:0]};
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < CH; i++) f[i] = IW'($urandom);
        return f;
    endfunction

    function automatic dframe_t rnd_dsp();
        dframe_t d;
        for (int i = 0; i < CH; i++) begin
            case ($urandom_range(0, 2))
                0:       d[i] = operand(IW'($urandom)) | DW'($urandom_range(0, (1 << FRAC) - 1));
                1:       d[i] = DW'({$urandom, $urandom});
                default: d[i] = m_din[i];
            endcase
        end
        return d;
    endfunction

    task automatic bump(input int k);
        if (m_cnt[k] < CMAX) m_cnt[k]++;
    endtask

    task automatic model_step();
        bit idle, tick_idle, consumed;
        logic [IW:0] s;
        logic [CH-1:0] newclip;
        if (rst) begin
            m_din = '0; m_out = '0; m_clip = '0; m_ov = 0; m_ss = -1;
            foreach (m_cnt[k]) m_cnt[k] = 0;
            pend_q.delete();
            return;
        end
        idle      = (m_ss < 0);
        tick_idle = idle && frame_tick;
        consumed  = 0;
        newclip   = '0;
        m_ov      = 0;
        if (frame_tick && !idle) bump(2);
        if (tick_idle) begin
            if (pend_q.size() != 0) m_din = operands(pend_q.pop_front());
            else if (in_valid) begin
                m_din = operands(in_bus);
                consumed = 1;
            end else bump(1);
        end
        if (in_valid && !consumed) begin
            if (pend_q.size() != 0) begin
                bump(0);
                pend_q.delete();
            end
            pend_q.push_back(in_bus);
        end
        if (m_ss >= 1 && dsp_done) begin
            for (int i = 0; i < CH; i++) begin
                s = sat_ref(dsp_out[i]);
                m_out[i] = s[IW-1:0];
                newclip[i] = s[IW];
            end
            m_ov = 1;
            m_ss = -1;
        end else if (m_ss == TO) begin
            bump(3);
            m_ss = -1;
        end else if (m_ss >= 0) begin
            m_ss++;
        end
        if (tick_idle) m_ss = 0;
        m_clip = (clip_clear ? '0 : m_clip) | newclip;
    endtask

    task automatic compare_all();
        check("dsp_start", 320'(dsp_start), 320'(m_ss == 0));
        check("busy", 320'(busy), 320'(m_ss >= 0));
        check("out_valid", 320'(out_valid), 320'(m_ov));
        check("clip", 320'(clip), 320'(m_clip));
        check("dsp_in", 320'(dsp_in), 320'(m_din));
        check("out_bus", 320'(out_bus), 320'(m_out));
        check("overrun_cnt", 320'(overrun_cnt), 320'(m_cnt[0]));
        check("underrun_cnt", 320'(underrun_cnt), 320'(m_cnt[1]));
        check("late_cnt", 320'(late_cnt), 320'(m_cnt[2]));
        check("timeout_cnt", 320'(timeout_cnt), 320'(m_cnt[3]));
    endtask

    task automatic step(input bit r, input bit iv, input bit ft, input bit dd, input bit cc);
        rst = r; in_valid = iv; frame_tick = ft; dsp_done = dd; clip_clear = cc;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        rst = 0; in_valid = 0; frame_tick = 0; dsp_done = 0; clip_clear = 0;
    endtask

    task automatic finish_frame(input dframe_t d, input int lat, input bit cc);
        dsp_out = d;
        repeat (lat) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, cc);
    endtask

    initial begin
        frame_t  fa, fb;
        dframe_t d;
        int      starts;
        bit      seen_ov;

        rst = 1; in_valid = 0; frame_tick = 0; dsp_done = 0; clip_clear = 0;
        in_bus = '0; dsp_out = '0;
        m_din = '0; m_out = '0; m_clip = '0; m_ov = 0; m_ss = -1;
        foreach (m_cnt[k]) m_cnt[k] = 0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("reset_cnts", 320'({overrun_cnt, underrun_cnt, late_cnt, timeout_cnt}), 320'(0));
        check("reset_flags", 320'({busy, dsp_start, out_valid, clip}), 320'(0));

        // basic frame
        in_bus = '0; in_bus[0] = 24'h100000;
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("basic_start", 320'(dsp_start), 320'(1));
        check("basic_din0", 320'(dsp_in[0]), 320'(36'h004000000));
        finish_frame(operands(in_bus), 9, 0);
        check("basic_valid", 320'(out_valid), 320'(1));
        check("basic_out0", 320'(out_bus[0]), 320'(24'h100000));
        check("basic_cnts", 320'({overrun_cnt, underrun_cnt, late_cnt, timeout_cnt}), 320'(0));

        // saturation and clip flags
        step(1, 0, 0, 0, 0);
        in_bus = rnd_frame();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        d = operands(in_bus);
        d[3] = 36'h080000000;
        finish_frame(d, 3, 0);
        check("sat_pos", 320'(out_bus[3]), 320'(24'h7FFFFF));
        check("clip_pos", 320'(clip[3]), 320'(1));
        step(0, 0, 1, 0, 0);
        d[3] = 36'hF00000000;
        finish_frame(d, 2, 1);
        check("sat_neg", 320'(out_bus[3]), 320'(24'h800000));
        check("clip_set_wins", 320'(clip[3]), 320'(1));
        step(0, 0, 0, 0, 1);
        check("clip_cleared", 320'(clip), 320'(0));

        // overrun, underrun, late tick
        step(1, 0, 0, 0, 0);
        fa = rnd_frame(); fb = rnd_frame();
        in_bus = fa; step(0, 1, 0, 0, 0);
        in_bus = fb; step(0, 1, 0, 0, 0);
        check("overrun_one", 320'(overrun_cnt), 320'(1));
        step(0, 0, 1, 0, 0);
        check("overrun_second_used", 320'(dsp_in), 320'(operands(fb)));
        finish_frame(rnd_dsp(), 4, 0);
        step(0, 0, 1, 0, 0);
        check("underrun_one", 320'(underrun_cnt), 320'(1));
        check("underrun_din_kept", 320'(dsp_in), 320'(operands(fb)));
        starts = 32'(dsp_start);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        starts += 32'(dsp_start);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0);
            starts += 32'(dsp_start);
        end
        check("late_one", 320'(late_cnt), 320'(1));
        check("late_single_start", 320'(starts), 320'(1));
        finish_frame(rnd_dsp(), 0, 0);

        // simultaneous in_valid and tick
        step(1, 0, 0, 0, 0);
        fa = rnd_frame(); fb = rnd_frame();
        in_bus = fa; step(0, 1, 0, 0, 0);
        in_bus = fb; step(0, 1, 1, 0, 0);
        check("simul_old_frame", 320'(dsp_in), 320'(operands(fa)));
        check("simul_no_overrun", 320'(overrun_cnt), 320'(0));
        finish_frame(rnd_dsp(), 2, 0);
        step(0, 0, 1, 0, 0);
        check("simul_pend_kept", 320'(dsp_in), 320'(operands(fb)));
        check("simul_no_underrun", 320'(underrun_cnt), 320'(0));
        finish_frame(rnd_dsp(), 2, 0);
        fa = rnd_frame();
        in_bus = fa; step(0, 1, 1, 0, 0);
        check("bypass_frame", 320'(dsp_in), 320'(operands(fa)));
        finish_frame(rnd_dsp(), 2, 0);
        step(0, 0, 1, 0, 0);
        check("bypass_pend_empty", 320'(underrun_cnt), 320'(1));
        finish_frame(rnd_dsp(), 1, 0);

        // timeout
        step(1, 0, 0, 0, 0);
        in_bus = rnd_frame();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        seen_ov = 0;
        for (int j = 1; j <= TO + 1; j++) begin
            step(0, 0, 0, 0, 0);
            seen_ov |= out_valid;
            if (j == TO) begin
                check("timeout_last_cycle_cnt", 320'(timeout_cnt), 320'(0));
                check("timeout_last_cycle_busy", 320'(busy), 320'(1));
            end
        end
        check("timeout_one", 320'(timeout_cnt), 320'(1));
        check("timeout_idle", 320'(busy), 320'(0));
        check("timeout_no_valid", 320'(seen_ov), 320'(0));
        step(0, 0, 0, 1, 0);
        check("late_done_ignored", 320'(out_valid), 320'(0));
        check("late_done_out", 320'(out_bus), 320'(0));

        // reset in RUN
        in_bus = rnd_frame();
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        finish_frame(rnd_dsp(), 2, 0);
        step(0, 0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_run_flags", 320'({dsp_start, busy, out_valid, clip}), 320'(0));
        check("rst_run_din", 320'(dsp_in), 320'(0));
        check("rst_run_out", 320'(out_bus), 320'(0));
        check("rst_run_cnts", 320'({overrun_cnt, underrun_cnt, late_cnt, timeout_cnt}), 320'(0));
        dsp_out = rnd_dsp();
        step(0, 0, 0, 1, 0);
        check("rst_done_ignored", 320'(out_valid), 320'(0));

        // counter saturation
        for (int n = 0; n < 20; n++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        check("underrun_sat", 320'(underrun_cnt), 320'(4'hF));

        // randomized traffic
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            in_bus  = rnd_frame();
            dsp_out = rnd_dsp();
            step($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
